// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencing controller.
package calc_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AS_EXEC,
        ST_MD_START,
        ST_MD_WAIT,
        ST_DONE
    } calc_state_t;

endpackage

// File: rtl/calc_md_watchdog.sv
// Cycle counter bounding how long the controller waits on the mul/div unit.
module calc_md_watchdog #(
    parameter int MD_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MD_TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the MD_TIMEOUT-th enabled cycle, i.e. as the count reaches the limit.
    assign expired = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/calc_op_ctrl.sv
// Operation sequencer: latches a request, steers add/sub or mul/div, captures the result.
module calc_op_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic [1:0]        op_q,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic              md_start,
    input  logic              md_done,
    input  logic [DATA_W-1:0] addsub_res,
    input  logic              addsub_ovf,
    input  logic [DATA_W-1:0] muldiv_res,
    input  logic              muldiv_err,
    output logic [DATA_W-1:0] res_out,
    output logic              ovf_out,
    output logic              err_out,
    output logic              res_valid
);

    calc_state_t       state_q, state_d;
    logic              busy_q, busy_d;
    logic [1:0]        op_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic              md_start_q, md_start_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              ovf_q, ovf_d, err_q, err_d;
    logic              res_valid_q, res_valid_d;
    logic              wd_expired;

    calc_md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ST_MD_START),
        .enable  (state_q == ST_MD_WAIT),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        md_start_d  = 1'b0;
        res_d       = res_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        res_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op_in;
                    opa_d = a_in;
                    opb_d = b_in;
                    if ((op_in == OP_ADD) || (op_in == OP_SUB)) begin
                        state_d = ST_AS_EXEC;
                    end else if ((op_in == OP_DIV) && (b_in == '0)) begin
                        // Divide-by-zero is resolved here; the mul/div unit is never started.
                        state_d     = ST_DONE;
                        res_d       = '0;
                        ovf_d       = 1'b0;
                        err_d       = 1'b1;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d    = ST_MD_START;
                        md_start_d = 1'b1;
                    end
                end
            end
            ST_AS_EXEC: begin
                state_d     = ST_DONE;
                res_d       = addsub_res;
                ovf_d       = addsub_ovf;
                err_d       = 1'b0;
                res_valid_d = 1'b1;
            end
            ST_MD_START: begin
                state_d = ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
                if (md_done) begin
                    state_d     = ST_DONE;
                    res_d       = muldiv_res;
                    ovf_d       = 1'b0;
                    err_d       = muldiv_err;
                    res_valid_d = 1'b1;
                end else if (wd_expired) begin
                    state_d     = ST_DONE;
                    res_d       = '0;
                    ovf_d       = 1'b0;
                    err_d       = 1'b1;
                    res_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            md_start_q  <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            md_start_q  <= md_start_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy      = busy_q;
    assign opa       = opa_q;
    assign opb       = opb_q;
    assign md_start  = md_start_q;
    assign res_out   = res_q;
    assign ovf_out   = ovf_q;
    assign err_out   = err_q;
    assign res_valid = res_valid_q;

endmodule
